// File: rtl/l1_tag_update_ctrl.sv
// l1_tag_update_ctrl
//   Arbitrates the single update port of the 4-way L1 tag/valid array between
//   L2 fill responses, single-line snoop invalidates and a whole-cache flush
//   walker. All tag-array controls leave this block from registers.
//
//   Optional feature macro: L1_TAG_UPDATE_FAIRNESS_EN
//     defined   -> after 3 consecutive invalidate grants with a fill waiting,
//                  the next grant goes to the fill.
//     undefined -> strict invalidate-over-fill priority (a fill can starve).
//
// Ports
//   clk, reset                     clock, synchronous active-low reset
//   fill_valid/ready, fill_way/tag/set     L2 fill request (valid/ready)
//   inv_valid/ready, inv_way/set           snoop invalidate (valid/ready)
//   flush_req                      one-cycle flush request pulse
//   flush_busy, flush_done         flush in progress / completion pulse
//   lookup_stall_o                 core must not issue tag accesses
//   update_o, invalidate_one_way_o, invalidate_all_ways_o   array strobes
//   update_way_o, update_tag_o, update_set_o               array fields
module l1_tag_update_ctrl #(
  parameter int NUM_SETS        = 64,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int TAG_WIDTH       = 26 - SET_INDEX_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [1:0]                 fill_way,
  input  logic [TAG_WIDTH-1:0]       fill_tag,
  input  logic [SET_INDEX_WIDTH-1:0] fill_set,
  input  logic                       inv_valid,
  output logic                       inv_ready,
  input  logic [1:0]                 inv_way,
  input  logic [SET_INDEX_WIDTH-1:0] inv_set,
  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic                       flush_done,
  output logic                       lookup_stall_o,
  output logic                       update_o,
  output logic                       invalidate_one_way_o,
  output logic                       invalidate_all_ways_o,
  output logic [1:0]                 update_way_o,
  output logic [TAG_WIDTH-1:0]       update_tag_o,
  output logic [SET_INDEX_WIDTH-1:0] update_set_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t                     state, state_nxt;
  logic [SET_INDEX_WIDTH-1:0] cnt, cnt_nxt;
  logic                       flush_pending, pend_nxt;

  logic                       busy_nxt, done_nxt;
  logic                       upd_nxt, inv1_nxt, invall_nxt;
  logic [1:0]                 way_nxt;
  logic [TAG_WIDTH-1:0]       tag_nxt;
  logic [SET_INDEX_WIDTH-1:0] set_nxt;

  logic flush_go;    // a flush is waiting to start (held or arriving now)
  logic fill_aged;   // fairness: the waiting fill must win the next grant
  logic fill_grant, inv_grant;

  assign flush_go   = flush_pending | flush_req;
  assign fill_ready = (state == IDLE) && !flush_go && (!inv_valid || fill_aged);
  assign inv_ready  = (state == IDLE) && !flush_go && !(fill_aged && fill_valid);
  assign fill_grant = fill_valid && fill_ready;
  assign inv_grant  = inv_valid && inv_ready;
  assign lookup_stall_o = flush_busy;

`ifdef L1_TAG_UPDATE_FAIRNESS_EN
  // Counts invalidate grants that went ahead of a waiting fill; saturates at 3.
  logic [1:0] fair_cnt;
  assign fill_aged = (fair_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset)                      fair_cnt <= 2'd0;
    else if (!fill_valid || fill_grant) fair_cnt <= 2'd0;
    else if (inv_grant && !fill_aged)   fair_cnt <= fair_cnt + 2'd1;
  end
`else
  assign fill_aged = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pend_nxt   = flush_pending | flush_req;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    upd_nxt    = 1'b0;
    inv1_nxt   = 1'b0;
    invall_nxt = 1'b0;
    way_nxt    = '0;
    tag_nxt    = '0;
    set_nxt    = '0;
    case (state)
      IDLE: begin
        if (flush_go) begin
          // Set 0 goes out with the first FLUSH cycle, so it is registered now.
          state_nxt  = FLUSH;
          cnt_nxt    = '0;
          pend_nxt   = 1'b0;
          busy_nxt   = 1'b1;
          invall_nxt = 1'b1;
        end else if (fill_grant) begin
          upd_nxt = 1'b1;
          way_nxt = fill_way;
          tag_nxt = fill_tag;
          set_nxt = fill_set;
        end else if (inv_grant) begin
          inv1_nxt = 1'b1;
          way_nxt  = inv_way;
          set_nxt  = inv_set;
        end
      end
      FLUSH: begin
        // cnt is the set currently on the outputs.
        busy_nxt = 1'b1;
        if (cnt == SET_INDEX_WIDTH'(NUM_SETS - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt    = cnt + 1'b1;
          invall_nxt = 1'b1;
          set_nxt    = cnt + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= IDLE;
      cnt                   <= '0;
      flush_pending         <= 1'b0;
      flush_busy            <= 1'b0;
      flush_done            <= 1'b0;
      update_o              <= 1'b0;
      invalidate_one_way_o  <= 1'b0;
      invalidate_all_ways_o <= 1'b0;
      update_way_o          <= '0;
      update_tag_o          <= '0;
      update_set_o          <= '0;
    end else begin
      state                 <= state_nxt;
      cnt                   <= cnt_nxt;
      flush_pending         <= pend_nxt;
      flush_busy            <= busy_nxt;
      flush_done            <= done_nxt;
      update_o              <= upd_nxt;
      invalidate_one_way_o  <= inv1_nxt;
      invalidate_all_ways_o <= invall_nxt;
      update_way_o          <= way_nxt;
      update_tag_o          <= tag_nxt;
      update_set_o          <= set_nxt;
    end
  end

endmodule

// File: tb/tb_l1_tag_update_ctrl.sv
// Bench for l1_tag_update_ctrl: directed test-plan scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// queue-based behavioural model of the expected array-port activity.
module tb_l1_tag_update_ctrl;
  localparam int NS  = 64;
  localparam int SIW = 6;
  localparam int TW  = 26 - SIW;
`ifdef L1_TAG_UPDATE_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  logic fill_valid = 0, inv_valid = 0, flush_req = 0;
  logic [1:0] fill_way = 0, inv_way = 0;
  logic [TW-1:0] fill_tag = 0;
  logic [SIW-1:0] fill_set = 0, inv_set = 0;
  logic fill_ready, inv_ready, flush_busy, flush_done, lookup_stall_o;
  logic update_o, invalidate_one_way_o, invalidate_all_ways_o;
  logic [1:0] update_way_o;
  logic [TW-1:0] update_tag_o;
  logic [SIW-1:0] update_set_o;

  always #5 clk = ~clk;

  l1_tag_update_ctrl #(.NUM_SETS(NS)) dut (
    .clk(clk), .reset(reset),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_set(fill_set),
    .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_way(inv_way), .inv_set(inv_set),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .lookup_stall_o(lookup_stall_o), .update_o(update_o),
    .invalidate_one_way_o(invalidate_one_way_o), .invalidate_all_ways_o(invalidate_all_ways_o),
    .update_way_o(update_way_o), .update_tag_o(update_tag_o), .update_set_o(update_set_o));

  // Expected port activity for one cycle.
  typedef struct packed {
    bit upd, inv1, invall, busy, done;
    bit [1:0] way;
    bit [TW-1:0] tag;
    bit [SIW-1:0] set;
  } exp_t;

  exp_t cur;           // what the outputs must show this cycle
  exp_t sched[$];      // future cycles already committed (flush walk)
  bit   pend;          // flush requested but not yet started
  int   fcnt;          // invalidates granted ahead of a waiting fill
  int   tests = 0, fails = 0;
  bit   g_fill, g_inv; // model grants of the cycle just completed

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] ev);
    tests++;
    if (act !== ev) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, ev, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance the model across posedge.
  task automatic tick();
    exp_t nx;
    bit idle, fl, aged, efr, eir;
    @(negedge clk);
    check("busy",    64'(flush_busy),            64'(cur.busy));
    check("stall",   64'(lookup_stall_o),        64'(cur.busy));
    check("done",    64'(flush_done),            64'(cur.done));
    check("update",  64'(update_o),              64'(cur.upd));
    check("inv_one", 64'(invalidate_one_way_o),  64'(cur.inv1));
    check("inv_all", 64'(invalidate_all_ways_o), 64'(cur.invall));
    if (cur.upd || cur.inv1) check("way", 64'(update_way_o), 64'(cur.way));
    if (cur.upd) check("tag", 64'(update_tag_o), 64'(cur.tag));
    if (cur.upd || cur.inv1 || cur.invall) check("set", 64'(update_set_o), 64'(cur.set));

    idle = !cur.busy;
    fl   = pend || flush_req;
    aged = FAIR && (fcnt == 3);
    efr  = idle && !fl && (!inv_valid || aged);
    eir  = idle && !fl && !(aged && fill_valid);
    check("fill_ready", 64'(fill_ready), 64'(efr));
    check("inv_ready",  64'(inv_ready),  64'(eir));
    g_fill = fill_valid && efr;
    g_inv  = inv_valid && eir;

    nx = '0;
    if (sched.size() > 0) nx = sched.pop_front();
    else if (idle && fl) begin
      for (int s = 0; s < NS; s++) begin
        exp_t e = '0;
        e.invall = 1; e.busy = 1; e.set = SIW'(s);
        sched.push_back(e);
      end
      begin
        exp_t e = '0;
        e.done = 1; e.busy = 1;
        sched.push_back(e);
      end
      nx = sched.pop_front();
    end else if (g_fill) begin
      nx.upd = 1; nx.way = fill_way; nx.tag = fill_tag; nx.set = fill_set;
    end else if (g_inv) begin
      nx.inv1 = 1; nx.way = inv_way; nx.set = inv_set;
    end

    if (idle && fl) pend = 0; else pend = pend | flush_req;
    if (!fill_valid || g_fill) fcnt = 0;
    else if (g_inv && fcnt < 3) fcnt++;

    if (!reset) begin
      nx = '0; sched.delete(); pend = 0; fcnt = 0;
    end
    @(posedge clk);
    cur = nx;
    #1;
  endtask

  int first, nall, nrdy, done_k, done2_k, ndone, seterr, k;

  initial begin
    cur = '0; pend = 0; fcnt = 0;
    // Reset state
    tick(); tick();
    check("rst_update", 64'(update_o), 64'd0);
    check("rst_busy",   64'(flush_busy), 64'd0);
    check("rst_invall", 64'(invalidate_all_ways_o), 64'd0);
    reset = 1; tick();

    // Fill only
    fill_valid = 1; fill_way = 2; fill_tag = TW'(20'h1ABCD); fill_set = 5;
    tick();
    fill_valid = 0;
    check("fill_upd",  64'(update_o),     64'd1);
    check("fill_way",  64'(update_way_o), 64'd2);
    check("fill_tag",  64'(update_tag_o), 64'h1ABCD);
    check("fill_set",  64'(update_set_o), 64'd5);
    tick();
    check("fill_one_cycle", 64'(update_o), 64'd0);

    // Fill and invalidate together
    fill_valid = 1; fill_way = 0; fill_tag = TW'(20'h00777); fill_set = 3;
    inv_valid = 1; inv_way = 1; inv_set = 7;
    tick();
    inv_valid = 0;
    check("both_inv_granted", 64'(g_inv), 64'd1);
    check("both_fill_waits",  64'(g_fill), 64'd0);
    check("both_inv1", 64'(invalidate_one_way_o), 64'd1);
    check("both_way",  64'(update_way_o), 64'd1);
    check("both_set",  64'(update_set_o), 64'd7);
    tick();
    fill_valid = 0;
    check("both_fill_next", 64'(g_fill), 64'd1);
    check("both_upd", 64'(update_o), 64'd1);
    tick();

    // Continuous invalidates with a fill waiting
    fill_valid = 1; fill_way = 3; fill_tag = TW'(20'h0F0F0); fill_set = 11;
    inv_valid = 1; inv_way = 2; inv_set = 9;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (g_fill && first < 0) begin first = i; fill_valid = 0; end
    end
    inv_valid = 0; fill_valid = 0;
    check("fair_first_fill", 64'(first), FAIR ? 64'd3 : 64'(-1));
    tick(); tick();

    // Single flush, fill held throughout
    fill_valid = 1; fill_way = 1; fill_tag = TW'(20'h00042); fill_set = 2;
    flush_req = 1; tick(); flush_req = 0;
    nall = 0; nrdy = 0; done_k = -1; seterr = 0;
    for (k = 1; k <= 66; k++) begin
      if (invalidate_all_ways_o) begin
        if (update_set_o != SIW'(nall)) seterr++;
        nall++;
      end
      if (flush_done && done_k < 0) done_k = k;
      if (k <= 65 && (fill_ready || inv_ready)) nrdy++;
      tick();
    end
    fill_valid = 0;
    check("flush_sets",      64'(nall),   64'd64);
    check("flush_set_order", 64'(seterr), 64'd0);
    check("flush_done_at",   64'(done_k), 64'd65);
    check("flush_ready_low", 64'(nrdy),   64'd0);
    tick(); tick();

    // Flush re-requested mid-walk
    flush_req = 1; tick(); flush_req = 0;
    nall = 0; ndone = 0; done2_k = -1;
    for (k = 1; k <= 140; k++) begin
      if (invalidate_all_ways_o) nall++;
      if (flush_done) begin ndone++; if (ndone == 2) done2_k = k; end
      if (k == 30) flush_req = 1;
      tick();
      flush_req = 0;
    end
    check("reflush_sets",  64'(nall),    64'd128);
    check("reflush_dones", 64'(ndone),   64'd2);
    check("reflush_done2", 64'(done2_k), 64'd131);

    // Reset during a flush at set 20
    flush_req = 1; tick(); flush_req = 0;
    for (k = 1; k < 40; k++) begin
      if (invalidate_all_ways_o && update_set_o == SIW'(20)) break;
      tick();
    end
    check("rst_mid_k", 64'(k), 64'd21);
    reset = 0; tick(); reset = 1;
    check("rstf_busy",   64'(flush_busy), 64'd0);
    check("rstf_invall", 64'(invalidate_all_ways_o), 64'd0);
    check("rstf_done",   64'(flush_done), 64'd0);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      if (flush_done) ndone++;
      tick();
    end
    check("rstf_no_done", 64'(ndone), 64'd0);
    fill_valid = 1; fill_way = 3; fill_tag = TW'(20'h00055); fill_set = 9;
    tick(); fill_valid = 0;
    check("rstf_fill_upd", 64'(update_o), 64'd1);
    check("rstf_fill_tag", 64'(update_tag_o), 64'h55);

    // Randomized traffic; payloads held until transferred
    g_fill = 0; g_inv = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!fill_valid || g_fill) begin
        fill_valid = ($urandom_range(0, 2) != 0);
        fill_way = 2'($urandom); fill_tag = TW'($urandom); fill_set = SIW'($urandom);
      end
      if (!inv_valid || g_inv) begin
        inv_valid = ($urandom_range(0, 4) != 0);
        inv_way = 2'($urandom); inv_set = SIW'($urandom);
      end
      flush_req = ($urandom_range(0, 149) == 0);
      reset     = ($urandom_range(0, 799) != 0);
      tick();
    end
    reset = 1; fill_valid = 0; inv_valid = 0; flush_req = 0;
    for (int i = 0; i < 150; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
